reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 35 +++
 tb/tb_reg_file.sv | 122 ++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: MIPS-style register file, two combinational read ports, one synchronous write port
// Ports:
//   ReadData1/ReadData2   - combinational read data for ReadRegister1/ReadRegister2
//   WriteData             - data stored into WriteRegister on a rising clk edge when RegWrite=1
//   ReadRegister1/2       - independent read addresses
//   WriteRegister         - write address; writes to register 0 are discarded
//   RegWrite              - write enable (X/Z behaves as no write)
//   clk                   - rising-edge clock
//   reset                 - synchronous active-high clear of every register, overrides a write
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic                  RegWrite,
    input  logic                  clk,
    input  logic                  reset
);
    logic [DATA_WIDTH-1:0] r_regs [2**ADDR_WIDTH];
    // An unknown enable evaluates false in the if, so the array is left alone
    always_ff @(posedge clk) begin
        if (reset)
            r_regs <= '{default: '0};
        else if (RegWrite && WriteRegister != '0)
            r_regs[WriteRegister] <= WriteData;
    end
    // Register 0 is forced to read zero so it is defined even before the first reset
    assign ReadData1 = (ReadRegister1 == '0) ? '0 : r_regs[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == '0) ? '0 : r_regs[ReadRegister2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized self-checking bench for reg_file against an array reference model
module tb_reg_file;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic        RegWrite, clk, reset;
    logic [31:0] model [32];
    int          n_checks, n_fails;

    reg_file dut (
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister), .RegWrite(RegWrite), .clk(clk), .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference semantics: reset clears all, otherwise a write to a nonzero address lands
    task automatic step();
        @(posedge clk);
        if (reset)
            for (int i = 0; i < 32; i++) model[i] = '0;
        else if (RegWrite === 1'b1 && WriteRegister != 5'd0)
            model[WriteRegister] = WriteData;
        #1;
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return a == 5'd0 ? 32'h0 : model[a];
    endfunction

    task automatic check_reads(input string tag);
        check({tag, "_rd1"}, ReadData1, ref_rd(ReadRegister1));
        check({tag, "_rd2"}, ReadData2, ref_rd(ReadRegister2));
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        for (int i = 0; i < 32; i++) model[i] = 'x;
        reset = 1'b0;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        #1;
        check("r0_pre_reset", ReadData1, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check("sweep_rd1", ReadData1, 32'h0);
            check("sweep_rd2", ReadData2, 32'h0);
        end
        RegWrite = 1'b1;
        WriteRegister = 5'd5;
        WriteData = 32'hDEADBEEF;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd5;
        #1;
        check("no_bypass_rd1", ReadData1, 32'h0);
        check("no_bypass_rd2", ReadData2, 32'h0);
        step();
        check("r5_rd1", ReadData1, 32'hDEADBEEF);
        check("r5_rd2", ReadData2, 32'hDEADBEEF);
        WriteRegister = 5'd0;
        WriteData = 32'hFFFFFFFF;
        ReadRegister1 = 5'd0;
        step();
        check("r0_write_discard", ReadData1, 32'h0);
        WriteRegister = 5'd1;
        WriteData = 32'h11111111;
        step();
        WriteRegister = 5'd31;
        WriteData = 32'h80000000;
        step();
        RegWrite = 1'b0;
        WriteRegister = 5'd1;
        WriteData = 32'h0;
        ReadRegister1 = 5'd1;
        ReadRegister2 = 5'd31;
        step();
        check("hold_r1", ReadData1, 32'h11111111);
        check("hold_r31", ReadData2, 32'h80000000);
        reset = 1'b1;
        RegWrite = 1'b1;
        WriteRegister = 5'd7;
        WriteData = 32'h12345678;
        ReadRegister1 = 5'd7;
        step();
        reset = 1'b0;
        RegWrite = 1'b0;
        check("reset_beats_write", ReadData1, 32'h0);
        check("reset_clears_r31", ReadData2, 32'h0);
        for (int c = 0; c < 1000; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            RegWrite = $urandom_range(0, 2) != 0;
            WriteRegister = 5'($urandom);
            WriteData = $urandom;
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            ReadRegister2 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            #1;
            check_reads("rand_pre");
            step();
            check_reads("rand_post");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
